// File: rtl/aes256_key_schedule_iter.sv
// Iterative AES-256 key schedule: accepts one 256-bit cipher key and streams
// round keys 0..14, one per accepted beat. All four S-boxes of the
// SubWord step are shared across every expansion step.

// AES S-box built from the GF(2^8) multiplicative inverse plus the affine map.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

    // Inverse as a^254 through a fixed addition chain (maps 0 to 0)
    always_comb begin
        x2   = gfMul(a_i, a_i);
        x3   = gfMul(x2, a_i);
        x6   = gfMul(x3, x3);
        x12  = gfMul(x6, x6);
        x15  = gfMul(x12, x3);
        x30  = gfMul(x15, x15);
        x60  = gfMul(x30, x30);
        x120 = gfMul(x60, x60);
        x240 = gfMul(x120, x120);
        x252 = gfMul(x240, x12);
        inv  = gfMul(x252, x2);
    end

    // Affine transform: b ^ rotl(b,1..4) ^ 0x63
    assign y_o = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

module aes256_key_schedule_iter (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [255:0] Key,
    input  logic         Key_valid,
    output logic         Key_ready,
    output logic [127:0] Round_key,
    output logic [3:0]   Round_key_idx,
    output logic         Round_key_last,
    output logic         Round_key_valid,
    input  logic         Round_key_ready
);

    localparam int AES_256_KEY_LENGTH = 256;
    localparam int AES_BLOCK_SIZE     = 128;
    localparam int AES_WORD_SIZE      = 32;
    localparam logic [3:0] LAST_IDX   = 4'd14;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                          state_q;
    logic [AES_256_KEY_LENGTH-1:0]   win_q;
    logic [AES_256_KEY_LENGTH-1:0]   win_d;
    logic [3:0]                      idx_q;
    logic                            last_q;
    logic                            valid_q;

    logic [AES_WORD_SIZE-1:0]        lastWord;
    logic [AES_WORD_SIZE-1:0]        subIn;
    logic [AES_WORD_SIZE-1:0]        subOut;
    logic [AES_WORD_SIZE-1:0]        tPrime;
    logic [7:0]                      rcon;
    logic [AES_WORD_SIZE-1:0]        o0, o1, o2, o3;
    logic [AES_BLOCK_SIZE-1:0]       nextRk;

    // Window holds {rk(k-1), rk(k-2)}; the next key k = idx+2 is even when idx is even
    assign lastWord = win_q[AES_256_KEY_LENGTH-1 -: AES_WORD_SIZE];
    assign subIn    = idx_q[0] ? lastWord : {lastWord[7:0], lastWord[31:8]};
    assign rcon     = idx_q[0] ? 8'h00 : (8'h01 << idx_q[3:1]);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gSbox
            aes_sbox uSbox (
                .a_i (subIn[8*g +: 8]),
                .y_o (subOut[8*g +: 8])
            );
        end
    endgenerate

    // Chain the XOR across the four words of the older round key
    always_comb begin
        tPrime = subOut ^ {24'h000000, rcon};
        o0     = win_q[31:0]   ^ tPrime;
        o1     = win_q[63:32]  ^ o0;
        o2     = win_q[95:64]  ^ o1;
        o3     = win_q[127:96] ^ o2;
        nextRk = {o3, o2, o1, o0};
        win_d  = {nextRk, win_q[AES_256_KEY_LENGTH-1:AES_BLOCK_SIZE]};
    end

    assign Key_ready       = (state_q == IDLE);
    assign Round_key       = win_q[AES_BLOCK_SIZE-1:0];
    assign Round_key_idx   = idx_q;
    assign Round_key_last  = last_q;
    assign Round_key_valid = valid_q;

    // Accept a key in IDLE, then slide the window one round key per accepted beat
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            idx_q   <= 4'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (Key_valid) begin
                state_q <= STREAM;
                win_q   <= Key;
                idx_q   <= 4'd0;
                last_q  <= 1'b0;
                valid_q <= 1'b1;
            end
        end else begin
            if (Round_key_ready) begin
                if (idx_q == LAST_IDX) begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end else begin
                    win_q  <= win_d;
                    idx_q  <= idx_q + 4'd1;
                    last_q <= (idx_q == LAST_IDX - 4'd1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes256_key_schedule_iter.sv
// Directed bench for the iterative AES-256 key schedule using the FIPS-197
// key 00..1f and an all-zero key.

module tb_aes256_key_schedule_iter;

    logic         Clk;
    logic         Rst_n;
    logic [255:0] Key;
    logic         Key_valid;
    logic         Key_ready;
    logic [127:0] Round_key;
    logic [3:0]   Round_key_idx;
    logic         Round_key_last;
    logic         Round_key_valid;
    logic         Round_key_ready;

    int compared;
    int mismatched;

    typedef struct {
        logic [3:0]   idx;
        logic         last;
        logic [127:0] rk;
    } vec_t;

    vec_t         vecs[19];
    logic [255:0] fipsKey;
    logic [255:0] zeroKey;

    aes256_key_schedule_iter dut (
        .Clk             (Clk),
        .Rst_n           (Rst_n),
        .Key             (Key),
        .Key_valid       (Key_valid),
        .Key_ready       (Key_ready),
        .Round_key       (Round_key),
        .Round_key_idx   (Round_key_idx),
        .Round_key_last  (Round_key_last),
        .Round_key_valid (Round_key_valid),
        .Round_key_ready (Round_key_ready)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // FIPS byte strings put byte 0 at the left; the DUT packs byte 0 at bits [7:0]
    function automatic logic [127:0] bswap128(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input int v, input string tag);
        checkOutput($sformatf("%s_valid%0d", tag, v), Round_key_valid, 128'd1);
        checkOutput($sformatf("%s_idx%0d", tag, v), Round_key_idx, vecs[v].idx);
        checkOutput($sformatf("%s_last%0d", tag, v), Round_key_last, vecs[v].last);
        checkOutput($sformatf("%s_rk%0d", tag, v), Round_key, vecs[v].rk);
    endtask

    // Offer a key at a falling edge with the consumer ready; returns where rk0 is visible
    task automatic applyStimulus(input logic [255:0] k, input string tag);
        checkOutput({tag, "_key_ready_idle"}, Key_ready, 128'd1);
        Key             = k;
        Key_valid       = 1'b1;
        Round_key_ready = 1'b1;
        @(negedge Clk);
        Key_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (Round_key_valid && n < 40) begin
            @(negedge Clk);
            n++;
        end
        checkOutput({tag, "_drained"}, Round_key_valid, 128'd0);
    endtask

    initial begin
        int e;
        int n;
        int s1;
        int s14;
        int cnt;

        compared   = 0;
        mismatched = 0;
        fipsKey = {bswap128(128'h101112131415161718191a1b1c1d1e1f),
                   bswap128(128'h000102030405060708090a0b0c0d0e0f)};
        zeroKey = '0;

        vecs[0]  = '{4'd0,  1'b0, bswap128(128'h000102030405060708090a0b0c0d0e0f)};
        vecs[1]  = '{4'd1,  1'b0, bswap128(128'h101112131415161718191a1b1c1d1e1f)};
        vecs[2]  = '{4'd2,  1'b0, bswap128(128'ha573c29fa176c498a97fce93a572c09c)};
        vecs[3]  = '{4'd3,  1'b0, bswap128(128'h1651a8cd0244beda1a5da4c10640bade)};
        vecs[4]  = '{4'd4,  1'b0, bswap128(128'hae87dff00ff11b68a68ed5fb03fc1567)};
        vecs[5]  = '{4'd5,  1'b0, bswap128(128'h6de1f1486fa54f9275f8eb5373b8518d)};
        vecs[6]  = '{4'd6,  1'b0, bswap128(128'hc656827fc9a799176f294cec6cd5598b)};
        vecs[7]  = '{4'd7,  1'b0, bswap128(128'h3de23a75524775e727bf9eb45407cf39)};
        vecs[8]  = '{4'd8,  1'b0, bswap128(128'h0bdc905fc27b0948ad5245a4c1871c2f)};
        vecs[9]  = '{4'd9,  1'b0, bswap128(128'h45f5a66017b2d387300d4d33640a820a)};
        vecs[10] = '{4'd10, 1'b0, bswap128(128'h7ccff71cbeb4fe5413e6bbf0d261a7df)};
        vecs[11] = '{4'd11, 1'b0, bswap128(128'hf01afafee7a82979d7a5644ab3afe640)};
        vecs[12] = '{4'd12, 1'b0, bswap128(128'h2541fe719bf500258813bbd55a721c0a)};
        vecs[13] = '{4'd13, 1'b0, bswap128(128'h4e5a6699a9f24fe07e572baacdf8cdea)};
        vecs[14] = '{4'd14, 1'b1, bswap128(128'h24fc79ccbf0979e9371ac23c6d68de36)};
        vecs[15] = '{4'd0,  1'b0, 128'h0};
        vecs[16] = '{4'd1,  1'b0, 128'h0};
        vecs[17] = '{4'd2,  1'b0, bswap128(128'h62636363626363636263636362636363)};
        vecs[18] = '{4'd3,  1'b0, bswap128(128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb)};

        Rst_n           = 1'b0;
        Key             = '0;
        Key_valid       = 1'b0;
        Round_key_ready = 1'b0;

        // Reset state
        @(negedge Clk);
        checkOutput("rst_valid", Round_key_valid, 128'd0);
        checkOutput("rst_key_ready", Key_ready, 128'd1);
        checkOutput("rst_idx", Round_key_idx, 128'd0);
        checkOutput("rst_last", Round_key_last, 128'd0);
        checkOutput("rst_rk", Round_key, 128'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // FIPS key with the consumer always ready: fifteen consecutive beats
        applyStimulus(fipsKey, "fips");
        for (int v = 0; v < 15; v++) begin
            checkBeat(v, "fips");
            checkOutput($sformatf("fips_key_ready_busy%0d", v), Key_ready, 128'd0);
            @(negedge Clk);
        end
        checkOutput("fips_end_valid", Round_key_valid, 128'd0);
        checkOutput("fips_end_key_ready", Key_ready, 128'd1);

        // All-zero key: first four round keys
        applyStimulus(zeroKey, "zero");
        for (int v = 15; v < 19; v++) begin
            checkBeat(v, "zero");
            @(negedge Clk);
        end
        drain("zero");

        // Pseudo-random backpressure with five-cycle stalls on idx 1 and idx 14
        applyStimulus(fipsKey, "stall");
        e   = 0;
        n   = 0;
        s1  = 0;
        s14 = 0;
        while (e < 15 && n < 300) begin
            checkBeat(e, "stall");
            if (e == 1 && s1 < 5) begin
                Round_key_ready = 1'b0;
                s1++;
            end else if (e == 14 && s14 < 5) begin
                Round_key_ready = 1'b0;
                s14++;
            end else begin
                Round_key_ready = 1'($urandom_range(0, 1));
            end
            @(posedge Clk);
            if (Round_key_ready) e++;
            @(negedge Clk);
            n++;
        end
        checkOutput("stall_all_beats", e, 128'd15);
        checkOutput("stall_end_valid", Round_key_valid, 128'd0);
        Round_key_ready = 1'b1;

        // Key_valid held high with a second key: measures the back-to-back period
        checkOutput("b2b_key_ready_idle", Key_ready, 128'd1);
        Key             = fipsKey;
        Key_valid       = 1'b1;
        Round_key_ready = 1'b1;
        cnt = 0;
        @(negedge Clk);
        cnt++;
        Key = zeroKey;
        for (int v = 0; v < 15; v++) begin
            checkBeat(v, "b2b");
            checkOutput($sformatf("b2b_key_ready_low%0d", v), Key_ready, 128'd0);
            @(negedge Clk);
            cnt++;
        end
        while (!Key_ready && cnt < 40) begin
            @(negedge Clk);
            cnt++;
        end
        checkOutput("b2b_period", cnt, 128'd16);
        checkOutput("b2b_gap_valid", Round_key_valid, 128'd0);
        @(negedge Clk);
        Key_valid = 1'b0;
        checkBeat(15, "b2b_second");
        @(negedge Clk);
        checkBeat(16, "b2b_second");
        drain("b2b");

        // Asynchronous reset in the middle of a stream, then a clean restart
        applyStimulus(fipsKey, "rst");
        for (int v = 0; v < 7; v++) begin
            checkBeat(v, "rst_pre");
            @(negedge Clk);
        end
        checkBeat(7, "rst_pre");
        Rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", Round_key_valid, 128'd0);
        checkOutput("rst_mid_key_ready", Key_ready, 128'd1);
        checkOutput("rst_mid_idx", Round_key_idx, 128'd0);
        checkOutput("rst_mid_rk", Round_key, 128'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        applyStimulus(fipsKey, "restart");
        for (int v = 0; v < 15; v++) begin
            checkBeat(v, "restart");
            @(negedge Clk);
        end
        checkOutput("restart_end_valid", Round_key_valid, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
